// File: rtl/bomb_countdown_timer.sv
// Bomb-game countdown: holds the remaining time as BCD digits, ticks faster as strikes accumulate,
// and reports a defused or exploded outcome. The begin_timer pulse realigns the external divider.
module bomb_countdown_timer #(
    parameter int START_MIN = 5,
    parameter int START_SEC = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       defused,
    input  logic [1:0] strikes,
    input  logic       one_hz_enable,
    input  logic       four_hz_enable,
    output logic       begin_timer,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       exploded,
    output logic       defused_done,
    output logic       blink
);

    typedef enum logic [1:0] {IDLE, RUNNING, DEFUSED, EXPLODED} state_t;

    localparam logic [3:0] START_MT = 4'(START_MIN / 10);
    localparam logic [3:0] START_MO = 4'(START_MIN % 10);
    localparam logic [3:0] START_ST = 4'(START_SEC / 10);
    localparam logic [3:0] START_SO = 4'(START_SEC % 10);

    state_t     state_reg;
    logic       toggle_reg;

    logic       enables_live;
    logic       tick_sel;
    logic       tick;
    logic       at_zero;
    logic       at_one;
    logic       under_ten;
    logic [3:0] mt_next, mo_next, st_next, so_next;

    // The divider is realigning while begin_timer is high, so its strobes are not trusted then.
    assign enables_live = (state_reg == RUNNING) && !begin_timer;

    always_comb begin
        tick_sel = 1'b0;
        case (strikes)
            2'd0:    tick_sel = one_hz_enable;
            2'd1:    tick_sel = four_hz_enable && toggle_reg;
            2'd2:    tick_sel = four_hz_enable;
            default: tick_sel = 1'b0;
        endcase
    end

    assign tick      = enables_live && tick_sel;
    assign under_ten = (min_tens == 4'd0) && (min_ones == 4'd0) && (sec_tens == 4'd0);
    assign at_zero   = under_ten && (sec_ones == 4'd0);
    assign at_one    = under_ten && (sec_ones == 4'd1);

    // BCD decrement with borrow; never evaluated at 00:00 because that state explodes first.
    always_comb begin
        mt_next = min_tens;
        mo_next = min_ones;
        st_next = sec_tens;
        so_next = sec_ones;
        if (sec_ones != 4'd0) begin
            so_next = sec_ones - 4'd1;
        end else begin
            so_next = 4'd9;
            if (sec_tens != 4'd0) begin
                st_next = sec_tens - 4'd1;
            end else begin
                st_next = 4'd5;
                if (min_ones != 4'd0) begin
                    mo_next = min_ones - 4'd1;
                end else begin
                    mo_next = 4'd9;
                    mt_next = min_tens - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= IDLE;
            toggle_reg   <= 1'b0;
            begin_timer  <= 1'b0;
            running      <= 1'b0;
            exploded     <= 1'b0;
            defused_done <= 1'b0;
            blink        <= 1'b0;
            min_tens     <= START_MT;
            min_ones     <= START_MO;
            sec_tens     <= START_ST;
            sec_ones     <= START_SO;
        end else begin
            begin_timer <= 1'b0;
            case (state_reg)
                RUNNING: begin
                    if (strikes == 2'd3 || (!defused && at_zero)) begin
                        state_reg <= EXPLODED;
                        running   <= 1'b0;
                        exploded  <= 1'b1;
                        blink     <= 1'b1;
                    end else if (defused) begin
                        state_reg    <= DEFUSED;
                        running      <= 1'b0;
                        defused_done <= 1'b1;
                        blink        <= 1'b0;
                    end else if (enables_live) begin
                        if (four_hz_enable) begin
                            toggle_reg <= ~toggle_reg;
                        end
                        if (!under_ten) begin
                            blink <= 1'b0;
                        end else if (four_hz_enable) begin
                            blink <= ~blink;
                        end
                        if (tick) begin
                            min_tens <= mt_next;
                            min_ones <= mo_next;
                            sec_tens <= st_next;
                            sec_ones <= so_next;
                            // Reaching 00:00 explodes on the same edge as the final tick.
                            if (at_one) begin
                                state_reg <= EXPLODED;
                                running   <= 1'b0;
                                exploded  <= 1'b1;
                                blink     <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    if (start) begin
                        state_reg    <= RUNNING;
                        toggle_reg   <= 1'b0;
                        begin_timer  <= 1'b1;
                        running      <= 1'b1;
                        exploded     <= 1'b0;
                        defused_done <= 1'b0;
                        blink        <= 1'b0;
                        min_tens     <= START_MT;
                        min_ones     <= START_MO;
                        sec_tens     <= START_ST;
                        sec_ones     <= START_SO;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bomb_countdown_timer.sv
// Scoreboard bench: four timers with different start values share one stimulus stream;
// expected outputs are queued per target timer and checked on the falling edge.
module tb_bomb_countdown_timer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       defused = 1'b0;
    logic [1:0] strikes = 2'd0;
    logic       one_hz_enable = 1'b0;
    logic       four_hz_enable = 1'b0;

    // {begin_timer, running, exploded, defused_done, blink, mt, mo, st, so}
    logic [20:0] obs [4];

    int vectors = 0;
    int miscompares = 0;

    logic [20:0] exp_q [$];
    int          sel_q [$];
    string       name_q [$];

    always #5 clock = ~clock;

    // Timer 0 starts at 05:00, 1 at 10:00, 2 at 00:12, 3 at 00:00.
    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        logic       bt, run, ex, dd, bl;
        logic [3:0] mt, mo, st, so;
        bomb_countdown_timer #(
            .START_MIN(gi == 0 ? 5 : (gi == 1 ? 10 : 0)),
            .START_SEC(gi == 2 ? 12 : 0)
        ) u_dut (
            .clock          (clock),
            .reset          (reset),
            .start          (start),
            .defused        (defused),
            .strikes        (strikes),
            .one_hz_enable  (one_hz_enable),
            .four_hz_enable (four_hz_enable),
            .begin_timer    (bt),
            .min_tens       (mt),
            .min_ones       (mo),
            .sec_tens       (st),
            .sec_ones       (so),
            .running        (run),
            .exploded       (ex),
            .defused_done   (dd),
            .blink          (bl)
        );
        assign obs[gi] = {bt, run, ex, dd, bl, mt, mo, st, so};
    end

    task automatic step(input logic st, input logic df, input logic oh, input logic fh);
        start = st;
        defused = df;
        one_hz_enable = oh;
        four_hz_enable = fh;
        @(posedge clock);
        #1;
        start = 1'b0;
        defused = 1'b0;
        one_hz_enable = 1'b0;
        four_hz_enable = 1'b0;
    endtask

    task automatic chk(input int sel, input string name, input logic bt, input logic run,
                       input logic ex, input logic dd, input logic bl, input logic [15:0] digits);
        exp_q.push_back({bt, run, ex, dd, bl, digits});
        sel_q.push_back(sel);
        name_q.push_back(name);
    endtask

    initial begin : monitor
        logic [20:0] e;
        logic [20:0] got;
        int          s;
        string       n;
        forever begin
            @(negedge clock);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                s = sel_q.pop_front();
                n = name_q.pop_front();
                got = obs[s];
                vectors++;
                if (got !== e) begin
                    miscompares++;
                    $display("FAIL %s dut%0d: got flags(bt,run,ex,dd,bl)=%b time=%h, want flags=%b time=%h",
                             n, s, got[20:16], got[15:0], e[20:16], e[15:0]);
                end else begin
                    $display("ok   %s dut%0d: flags=%b time=%h", n, s, got[20:16], got[15:0]);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        // Reset state
        step(0, 0, 0, 0);
        chk(0, "reset5", 0, 0, 0, 0, 0, 16'h0500);
        chk(1, "reset10", 0, 0, 0, 0, 0, 16'h1000);
        chk(2, "reset12", 0, 0, 0, 0, 0, 16'h0012);
        reset = 1'b0;
        step(0, 0, 1, 1);
        chk(0, "idle_ignores_enables", 0, 0, 0, 0, 0, 16'h0500);

        // Round 1: normal seconds countdown and borrow chain
        step(1, 0, 0, 0);
        chk(0, "start_pulse", 1, 1, 0, 0, 0, 16'h0500);
        chk(3, "zero_start", 1, 1, 0, 0, 0, 16'h0000);
        step(0, 0, 1, 0);
        chk(0, "bt_cycle_ignores_tick", 0, 1, 0, 0, 0, 16'h0500);
        chk(3, "zero_explodes", 0, 0, 1, 0, 1, 16'h0000);
        step(0, 0, 0, 1);
        chk(0, "s0_ignores_4hz", 0, 1, 0, 0, 0, 16'h0500);
        step(0, 0, 1, 0);
        chk(0, "tick1", 0, 1, 0, 0, 0, 16'h0459);
        chk(1, "borrow_chain", 0, 1, 0, 0, 0, 16'h0959);
        step(0, 0, 1, 0);
        chk(0, "tick2", 0, 1, 0, 0, 0, 16'h0458);
        step(0, 0, 1, 0);
        chk(0, "tick3", 0, 1, 0, 0, 0, 16'h0457);
        repeat (537) step(0, 0, 1, 0);
        chk(1, "one_minute", 0, 1, 0, 0, 0, 16'h0100);
        chk(0, "expired_5min", 0, 0, 1, 0, 1, 16'h0000);
        step(0, 0, 1, 0);
        chk(1, "minute_borrow", 0, 1, 0, 0, 0, 16'h0059);

        // Strike speeds on the 10:00 timer
        strikes = 2'd1;
        repeat (8) step(0, 0, 0, 1);
        chk(1, "strikes1_half_rate", 0, 1, 0, 0, 0, 16'h0055);
        strikes = 2'd2;
        repeat (8) step(0, 0, 0, 1);
        chk(1, "strikes2_full_rate", 0, 1, 0, 0, 0, 16'h0047);
        strikes = 2'd3;
        step(0, 0, 0, 0);
        chk(1, "strikes3_explode", 0, 0, 1, 0, 1, 16'h0047);
        step(0, 0, 1, 0);
        step(0, 0, 0, 1);
        chk(1, "exploded_hold", 0, 0, 1, 0, 1, 16'h0047);
        strikes = 2'd0;

        // Round 2: expiry and blink on the 00:12 timer
        step(1, 0, 0, 0);
        chk(2, "r2_start", 1, 1, 0, 0, 0, 16'h0012);
        chk(1, "restart_after_explode", 1, 1, 0, 0, 0, 16'h1000);
        step(0, 0, 0, 0);
        chk(2, "r2_running", 0, 1, 0, 0, 0, 16'h0012);
        step(0, 0, 1, 0);
        chk(2, "t11", 0, 1, 0, 0, 0, 16'h0011);
        step(0, 0, 1, 0);
        chk(2, "t10", 0, 1, 0, 0, 0, 16'h0010);
        step(0, 0, 0, 1);
        chk(2, "no_blink_at_10", 0, 1, 0, 0, 0, 16'h0010);
        step(1, 0, 0, 0);
        chk(2, "start_ignored_running", 0, 1, 0, 0, 0, 16'h0010);
        step(0, 0, 1, 0);
        chk(2, "t09", 0, 1, 0, 0, 0, 16'h0009);
        step(0, 0, 0, 1);
        chk(2, "blink_on", 0, 1, 0, 0, 1, 16'h0009);
        step(0, 0, 0, 1);
        chk(2, "blink_off", 0, 1, 0, 0, 0, 16'h0009);
        step(0, 0, 0, 1);
        chk(2, "blink_on2", 0, 1, 0, 0, 1, 16'h0009);
        for (int i = 8; i >= 1; i--) begin
            step(0, 0, 1, 0);
            chk(2, "final_countdown", 0, 1, 0, 0, 1, 16'(i));
        end
        step(0, 0, 1, 0);
        chk(2, "expire", 0, 0, 1, 0, 1, 16'h0000);
        step(0, 0, 0, 1);
        step(0, 0, 1, 0);
        chk(2, "post_expire_hold", 0, 0, 1, 0, 1, 16'h0000);

        // Round 3: defuse on the 05:00 timer, then restart and reset mid-run
        strikes = 2'd3;
        step(0, 0, 0, 0);
        strikes = 2'd0;
        step(1, 0, 0, 0);
        chk(0, "r3_start", 1, 1, 0, 0, 0, 16'h0500);
        step(0, 0, 0, 0);
        repeat (150) step(0, 0, 1, 0);
        chk(0, "at_0230", 0, 1, 0, 0, 0, 16'h0230);
        step(0, 1, 1, 0);
        chk(0, "defuse_beats_tick", 0, 0, 0, 1, 0, 16'h0230);
        step(0, 0, 1, 0);
        step(0, 0, 0, 1);
        chk(0, "defused_hold", 0, 0, 0, 1, 0, 16'h0230);
        step(1, 0, 0, 0);
        chk(0, "restart_after_defuse", 1, 1, 0, 0, 0, 16'h0500);
        step(0, 0, 0, 0);
        repeat (103) step(0, 0, 1, 0);
        chk(0, "at_0317", 0, 1, 0, 0, 0, 16'h0317);
        reset = 1'b1;
        step(1, 0, 1, 0);
        chk(0, "reset_beats_start_tick", 0, 0, 0, 0, 0, 16'h0500);
        reset = 1'b0;
        step(0, 0, 0, 0);
        chk(0, "no_bt_after_reset", 0, 0, 0, 0, 0, 16'h0500);

        repeat (3) @(posedge clock);
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
